// File: rtl/rgb565_yuv_conv.sv
// rtl/rgb565_yuv_conv.sv - two-stage pipelined RGB565 to full-range BT.601 YCbCr converter
module rgb565_yuv_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        rgb_valid,
    input  logic [15:0] rgb_in,
    output logic [7:0]  y_out,
    output logic [7:0]  u_out,
    output logic [7:0]  v_out,
    output logic        yuv_valid
);
    localparam int LATENCY = 2;

    logic [7:0] r8, g8, b8;
    logic signed [17:0] r_s, g_s, b_s;

    assign r8  = {rgb_in[15:11], rgb_in[15:13]};
    assign g8  = {rgb_in[10:5],  rgb_in[10:9]};
    assign b8  = {rgb_in[4:0],   rgb_in[4:2]};
    assign r_s = signed'({10'd0, r8});
    assign g_s = signed'({10'd0, g8});
    assign b_s = signed'({10'd0, b8});

    logic signed [17:0] p_yr, p_yg, p_yb;
    logic signed [17:0] p_ur, p_ug, p_ub;
    logic signed [17:0] p_vr, p_vg, p_vb;
    logic [LATENCY-1:0] vld_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_yr <= '0; p_yg <= '0; p_yb <= '0;
            p_ur <= '0; p_ug <= '0; p_ub <= '0;
            p_vr <= '0; p_vg <= '0; p_vb <= '0;
        end else begin
            p_yr <= r_s * 18'sd77;
            p_yg <= g_s * 18'sd150;
            p_yb <= b_s * 18'sd29;
            p_ur <= r_s * -18'sd43;
            p_ug <= g_s * -18'sd85;
            p_ub <= b_s * 18'sd128;
            p_vr <= r_s * 18'sd128;
            p_vg <= g_s * -18'sd107;
            p_vb <= b_s * -18'sd21;
        end
    end

    logic signed [19:0] sum_y, sum_u, sum_v;
    logic signed [19:0] res_y, res_u, res_v;

    // Rounding bias is added before the arithmetic shift, so negatives floor.
    always_comb begin
        sum_y = 20'(p_yr) + 20'(p_yg) + 20'(p_yb) + 20'sd128;
        sum_u = 20'(p_ur) + 20'(p_ug) + 20'(p_ub) + 20'sd128;
        sum_v = 20'(p_vr) + 20'(p_vg) + 20'(p_vb) + 20'sd128;
        res_y = sum_y >>> 8;
        res_u = (sum_u >>> 8) + 20'sd128;
        res_v = (sum_v >>> 8) + 20'sd128;
    end

    function automatic logic [7:0] clamp8(input logic signed [19:0] x);
        if (x < 20'sd0)
            return 8'd0;
        else if (x > 20'sd255)
            return 8'd255;
        else
            return x[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out <= '0;
            u_out <= '0;
            v_out <= '0;
        end else begin
            y_out <= clamp8(res_y);
            u_out <= clamp8(res_u);
            v_out <= clamp8(res_v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_sr <= '0;
        else
            vld_sr <= {vld_sr[LATENCY-2:0], rgb_valid};
    end

    assign yuv_valid = vld_sr[LATENCY-1];
endmodule

// File: tb/tb_rgb565_yuv_conv.sv
// tb/tb_rgb565_yuv_conv.sv - self-checking bench for rgb565_yuv_conv
`timescale 1ns/1ps
module tb_rgb565_yuv_conv;
    logic        clk = 1'b0;
    logic        rst;
    logic        rgb_valid;
    logic [15:0] rgb_in;
    logic [7:0]  y_out, u_out, v_out;
    logic        yuv_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       vld;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } exp_t;

    exp_t hist[$];

    always #5 clk = ~clk;

    rgb565_yuv_conv dut (
        .clk(clk), .rst(rst), .rgb_valid(rgb_valid), .rgb_in(rgb_in),
        .y_out(y_out), .u_out(u_out), .v_out(v_out), .yuv_valid(yuv_valid)
    );

    function automatic int floor_div256(input int s);
        if (s >= 0) return s / 256;
        return -((-s + 255) / 256);
    endfunction

    function automatic int sat(input int x);
        return (x < 0) ? 0 : (x > 255) ? 255 : x;
    endfunction

    function automatic exp_t ref_model(input logic v, input logic [15:0] p);
        int r5, g6, b5, r, g, b;
        exp_t e;
        r5 = int'(p[15:11]); g6 = int'(p[10:5]); b5 = int'(p[4:0]);
        r = r5 * 8 + r5 / 4;
        g = g6 * 4 + g6 / 16;
        b = b5 * 8 + b5 / 4;
        e.vld = v;
        e.y  = 8'(sat(floor_div256(77 * r + 150 * g + 29 * b + 128)));
        e.cb = 8'(sat(floor_div256(-43 * r - 85 * g + 128 * b + 128) + 128));
        e.cr = 8'(sat(floor_div256(128 * r - 107 * g - 21 * b + 128) + 128));
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        exp_t e;
        e = hist[hist.size() - 2];
        chk("yuv_valid", int'(yuv_valid), int'(e.vld));
        if (e.vld) begin
            chk("y_out", int'(y_out), int'(e.y));
            chk("u_out", int'(u_out), int'(e.cb));
            chk("v_out", int'(v_out), int'(e.cr));
        end
    endtask

    // Drive at negedge, sample #1 after the posedge; output reflects the pixel taken one edge earlier.
    task automatic cycle(input logic v, input logic [15:0] p);
        rgb_valid = v;
        rgb_in    = p;
        @(posedge clk);
        hist.push_back(ref_model(v, p));
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic chk_yuv(input string tag, input int ey, input int eu, input int ev);
        chk({tag, "_valid"}, int'(yuv_valid), 1);
        chk({tag, "_y"}, int'(y_out), ey);
        chk({tag, "_u"}, int'(u_out), eu);
        chk({tag, "_v"}, int'(v_out), ev);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(yuv_valid), 0);
        chk({tag, "_y"}, int'(y_out), 0);
        chk({tag, "_u"}, int'(u_out), 0);
        chk({tag, "_v"}, int'(v_out), 0);
    endtask

    task automatic clear_hist();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
    endtask

    initial begin
        rst = 1'b1;
        rgb_valid = 1'b0;
        rgb_in = 16'h0000;
        clear_hist();
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed pixels with hand-computed results, each followed by one idle cycle.
        cycle(1'b1, 16'h8610); cycle(1'b0, 16'h0000); chk_yuv("mid", 169, 107, 102);
        cycle(1'b1, 16'hFFFF); cycle(1'b0, 16'h0000); chk_yuv("white", 255, 128, 128);
        cycle(1'b1, 16'h0000); cycle(1'b0, 16'h0000); chk_yuv("black", 0, 128, 128);
        cycle(1'b1, 16'hF800); cycle(1'b0, 16'h0000); chk_yuv("red", 77, 85, 255);
        cycle(1'b1, 16'h001F); cycle(1'b0, 16'h0000); chk_yuv("blue", 29, 255, 107);
        cycle(1'b0, 16'h0000);

        // Streaming sequence with a one-cycle bubble.
        cycle(1'b1, 16'hFFFF);
        cycle(1'b1, 16'h0000); chk_yuv("s0", 255, 128, 128);
        cycle(1'b1, 16'hF800); chk_yuv("s1", 0, 128, 128);
        cycle(1'b1, 16'h001F); chk_yuv("s2", 77, 85, 255);
        cycle(1'b0, 16'h1234); chk_yuv("s3", 29, 255, 107);
        cycle(1'b1, 16'hFFFF); chk("s_gap", int'(yuv_valid), 0);
        cycle(1'b0, 16'h0000); chk_yuv("s4", 255, 128, 128);

        // Randomized pixels and valid pattern against the reference model.
        for (int i = 0; i < 300; i++)
            cycle(1'(($urandom % 4) != 0), 16'($urandom));

        // Asynchronous reset mid-stream, away from a clock edge.
        cycle(1'b1, 16'hFFFF);
        cycle(1'b1, 16'hF800);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        rgb_valid = 1'b1;
        rgb_in    = 16'h001F;
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold");
        @(negedge clk);
        rgb_valid = 1'b0;
        rst = 1'b0;
        clear_hist();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 16'hFFFF);
        cycle(1'b1, 16'h8610);
        cycle(1'b0, 16'h0000); chk_yuv("post_rst", 169, 107, 102);
        cycle(1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
